// File: rtl/mem_rsp_pkg.sv
// Shared types and helpers for the external-memory responder.
package mem_rsp_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Default word width of the cache external port; the array is word addressed.
  localparam int unsigned WORD_SIZE_DEF = 32;
  localparam int unsigned WORD_BYTES    = WORD_SIZE_DEF / 8;

  // A byte address is legal when it is word aligned and every bit above the
  // array index field is zero.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned addr_bits);
    logic [31:0] upper;
    upper = addr >> (addr_bits + 2);
    return (addr[1:0] == 2'b00) && (upper == 32'd0);
  endfunction

endpackage

// File: rtl/sp_word_ram.sv
// Synchronous single-port word RAM with a registered read port.
module sp_word_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  // Write when enabled; the read port returns the pre-write contents (read-first).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/ext_mem_responder.sv
// Fixed-latency responder for the cache external-memory port, backed by a
// word-addressed single-port RAM. Illegal requests get a one-cycle error ack.
module ext_mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_BITS = 14,
  parameter int LATENCY   = 4,
  parameter int CNT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          req_addr,
  input  logic [WORD_SIZE-1:0] req_data,
  input  logic                 req_re,
  input  logic                 req_wr,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_ack,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam logic [CNT_BITS-1:0] LAT_M1  = CNT_BITS'(LATENCY - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic                LAT_ONE = (LATENCY == 1);

  state_e               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 wr_q, wr_d;
  logic                 err_q, err_d;
  logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;

  logic                 req_any;
  logic                 req_legal;
  logic [ADDR_BITS-1:0] req_idx;

  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [WORD_SIZE-1:0] ram_din;
  logic [WORD_SIZE-1:0] ram_dout;

  assign req_any   = req_re | req_wr;
  assign req_legal = addr_legal(req_addr, ADDR_BITS) && (req_re != req_wr);
  assign req_idx   = req_addr[ADDR_BITS+1:2];

  // In IDLE the RAM sees the live request so a LATENCY=1 access can commit on
  // the sample edge; afterwards it sees the captured request.
  assign ram_addr = (state_q == IDLE) ? req_idx  : addr_q;
  assign ram_din  = (state_q == IDLE) ? req_data : data_q;
  assign ram_we   = !rst &&
                    (((state_q == WAIT) && (cnt_q == CNT_ONE) && wr_q && !err_q) ||
                     ((state_q == IDLE) && LAT_ONE && req_legal && req_wr));

  sp_word_ram #(
    .DATA_W (WORD_SIZE),
    .ADDR_W (ADDR_BITS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // Next-state logic: request capture, latency countdown and response.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = wr_q;
    err_d      = err_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          addr_d = req_idx;
          data_d = req_data;
          wr_d   = req_wr;
          cnt_d  = LAT_M1;
          if (req_legal) begin
            err_d   = 1'b0;
            state_d = LAT_ONE ? ACK : WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = ACK;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
        // The RAM read issued on the commit edge is visible during ACK;
        // keep it so rsp_data holds until the next legal read.
        if (!err_q && !wr_q) begin
          rsp_data_d = ram_dout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      err_q      <= err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Captured request address and write data; never reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // During the ACK of a legal read the fresh RAM output is presented directly.
  assign rsp_data = ((state_q == ACK) && !err_q && !wr_q) ? ram_dout : rsp_data_q;
  assign rsp_ack  = (state_q == ACK);
  assign rsp_err  = (state_q == ACK) && err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed testbench for ext_mem_responder (LATENCY=4, ADDR_BITS=14).
module tb_ext_mem_responder;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_re;
  logic        req_wr;
  logic [31:0] rsp_data;
  logic        rsp_ack;
  logic        rsp_err;
  logic        busy;

  int n_vec;
  int n_err;
  int cyc;

  ext_mem_responder #(
    .WORD_SIZE (32),
    .ADDR_BITS (14),
    .LATENCY   (LAT),
    .CNT_BITS  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_re   (req_re),
    .req_wr   (req_wr),
    .rsp_data (rsp_data),
    .rsp_ack  (rsp_ack),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Issue one request from an IDLE cycle (#1 after an edge). Returns the
  // number of edges from sample to the edge where the ack is taken (-1 on
  // timeout), busy cycles, data/err seen in the ack cycle and rsp_ack one
  // cycle later. Returns #1 after the edge that ends the ACK cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic re, input logic wr,
                       output int lat, output int bsy,
                       output logic [31:0] rd, output logic er,
                       output logic ack2);
    req_addr = a; req_data = d; req_re = re; req_wr = wr;
    @(posedge clk); #1;
    lat = 1;
    bsy = 0;
    while (rsp_ack !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    if (rsp_ack !== 1'b1) lat = -1;
    if (busy === 1'b1) bsy++;
    rd = rsp_data;
    er = rsp_err;
    req_re = 1'b0; req_wr = 1'b0;
    @(posedge clk); #1;
    ack2 = rsp_ack;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_addr = '0; req_data = '0; req_re = 1'b0; req_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data got=%h exp=%h", rsp_data, 32'h0); end
    n_vec++; if (rsp_ack !== 1'b0) begin n_err++; $display("FAIL reset_rsp_ack got=%b exp=0", rsp_ack); end
    n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_latency();
    int lat, bsy; logic [31:0] rd; logic er, a2;
    issue(32'hF0, 32'hFFFF_FFFF, 1'b0, 1'b1, lat, bsy, rd, er, a2);
    n_vec++; if (lat != LAT) begin n_err++; $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT); end
    n_vec++; if (bsy != LAT) begin n_err++; $display("FAIL wr_busy_cycles got=%0d exp=%0d", bsy, LAT); end
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL wr_err got=%b exp=0", er); end
    n_vec++; if (a2 !== 1'b0) begin n_err++; $display("FAIL wr_ack_one_cycle got=%b exp=0", a2); end
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL wr_keeps_rsp_data got=%h exp=%h", rd, 32'h0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_read();
    int lat, bsy; logic [31:0] rd; logic er, a2;
    issue(32'h40, 32'h0, 1'b1, 1'b0, lat, bsy, rd, er, a2);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rd_unwritten got=%h exp=%h", rd, 32'h0); end
    n_vec++; if (lat != LAT) begin n_err++; $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT); end
    issue(32'hF0, 32'h0, 1'b1, 1'b0, lat, bsy, rd, er, a2);
    n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rd_after_wr got=%h exp=%h", rd, 32'hFFFF_FFFF); end
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL rd_err got=%b exp=0", er); end
    n_vec++; if (a2 !== 1'b0) begin n_err++; $display("FAIL rd_ack_one_cycle got=%b exp=0", a2); end
    n_vec++; if (rsp_data !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rd_data_hold got=%h exp=%h", rsp_data, 32'hFFFF_FFFF); end
  endtask

  task automatic test_illegal();
    int lat, bsy; logic [31:0] rd; logic er, a2;
    issue(32'h1, 32'h0, 1'b1, 1'b0, lat, bsy, rd, er, a2);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL misalign_latency got=%0d exp=1", lat); end
    n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL misalign_err got=%b exp=1", er); end
    n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL misalign_data_kept got=%h exp=%h", rd, 32'hFFFF_FFFF); end
    n_vec++; if (a2 !== 1'b0) begin n_err++; $display("FAIL misalign_ack_one_cycle got=%b exp=0", a2); end
    issue(32'h1_0000, 32'h0, 1'b1, 1'b0, lat, bsy, rd, er, a2);
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL range_latency got=%0d exp=1", lat); end
    n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL range_err got=%b exp=1", er); end
    n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL range_data_kept got=%h exp=%h", rd, 32'hFFFF_FFFF); end
    // Illegal writes that would alias onto word 0xF0 must not touch the array.
    issue(32'hF1, 32'h1234_5678, 1'b0, 1'b1, lat, bsy, rd, er, a2);
    n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL misalign_wr_err got=%b exp=1", er); end
    issue(32'h1_00F0, 32'h0BAD_0BAD, 1'b0, 1'b1, lat, bsy, rd, er, a2);
    n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL range_wr_err got=%b exp=1", er); end
    issue(32'hF0, 32'h0, 1'b1, 1'b0, lat, bsy, rd, er, a2);
    n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL illegal_no_array_change got=%h exp=%h", rd, 32'hFFFF_FFFF); end
  endtask

  task automatic test_both();
    int lat, bsy; logic [31:0] rd; logic er, a2;
    issue(32'h20, 32'h1122_3344, 1'b0, 1'b1, lat, bsy, rd, er, a2);
    issue(32'h20, 32'hDEAD_BEEF, 1'b1, 1'b1, lat, bsy, rd, er, a2);
    n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL both_err got=%b exp=1", er); end
    n_vec++; if (lat != 1) begin n_err++; $display("FAIL both_latency got=%0d exp=1", lat); end
    issue(32'h20, 32'h0, 1'b1, 1'b0, lat, bsy, rd, er, a2);
    n_vec++; if (rd !== 32'h1122_3344) begin n_err++; $display("FAIL both_no_write got=%h exp=%h", rd, 32'h1122_3344); end
  endtask

  task automatic test_reset_mid();
    int lat, bsy; logic [31:0] rd; logic er, a2;
    logic seen_ack;
    // Reset in the second WAIT cycle.
    req_addr = 32'h20; req_data = 32'hA5A5_A5A5; req_re = 1'b0; req_wr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_vec++; if (rsp_data !== 32'h0) begin n_err++; $display("FAIL rstmid_rsp_data got=%h exp=%h", rsp_data, 32'h0); end
    seen_ack = rsp_ack;
    repeat (LAT + 1) begin
      @(posedge clk); #1;
      seen_ack = seen_ack | rsp_ack;
    end
    n_vec++; if (seen_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_no_ack got=%b exp=0", seen_ack); end
    // Reset on the commit edge itself.
    req_addr = 32'h20; req_data = 32'h5A5A_5A5A; req_re = 1'b0; req_wr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++; if (rsp_ack !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rstcommit_state got ack=%b busy=%b exp ack=0 busy=0", rsp_ack, busy); end
    issue(32'h20, 32'h0, 1'b1, 1'b0, lat, bsy, rd, er, a2);
    n_vec++; if (rd !== 32'h1122_3344) begin n_err++; $display("FAIL rst_no_write got=%h exp=%h", rd, 32'h1122_3344); end
  endtask

  task automatic test_back_to_back();
    int lat, bsy; logic [31:0] rd; logic er, a2;
    int acks, t0, bad_lat;
    for (int i = 0; i < 16; i++) begin
      issue(32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i * 32'h0101), 1'b0, 1'b1, lat, bsy, rd, er, a2);
    end
    acks = 0; bad_lat = 0;
    t0 = cyc;
    for (int i = 0; i < 16; i++) begin
      issue(32'h100 + 32'(4 * i), 32'h0, 1'b1, 1'b0, lat, bsy, rd, er, a2);
      if (lat > 0) acks++;
      if (lat != LAT) bad_lat++;
      n_vec++;
      if (rd !== 32'hC0DE_0000 + 32'(i * 32'h0101)) begin
        n_err++;
        $display("FAIL fill_data[%0d] got=%h exp=%h", i, rd, 32'hC0DE_0000 + 32'(i * 32'h0101));
      end
    end
    n_vec++; if (acks != 16) begin n_err++; $display("FAIL fill_ack_count got=%0d exp=16", acks); end
    n_vec++; if (bad_lat != 0) begin n_err++; $display("FAIL fill_latency bad=%0d exp=0", bad_lat); end
    n_vec++; if (cyc - t0 != 16 * (LAT + 1)) begin n_err++; $display("FAIL fill_total_cycles got=%0d exp=%0d", cyc - t0, 16 * (LAT + 1)); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    test_reset();
    test_write_latency();
    test_read();
    test_illegal();
    test_both();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
